uart_loopback_fifo: RTL and testbench
=====================================

// Module: uart_loopback_fifo
// PURPOSE
//  Parametrised full-duplex UART with RX and TX FIFOs and a run-time loopback switch.
//  Baud divisor is derived from CLK_HZ/BAUD; no external baud-tick blocks are needed.
//  Sits between the board pins and on-chip logic, and replaces the fixed 8N1 unbuffered echo path.
//  With loopback_en=1, received bytes are retransmitted internally.
//  With loopback_en=0, both directions are exposed to the host through valid/ready ports.
// PARAMETERS
//  CLK_HZ      25_000_000  input clock frequency, Hz
//  BAUD        9600        line rate; DIV = CLK_HZ/BAUD (integer, must be >= 4)
//  DATA_BITS   8           bits per frame, 5..9
//  FIFO_DEPTH  16          entries per FIFO, power of two, >= 2
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous reset, active-high
//  uart_rx      in   1          serial input, idle high
//  uart_tx      out  1          serial output, idle high
//  loopback_en  in   1          1 = RX FIFO drains into TX FIFO; host ports are blocked
//  tx_data      in   DATA_BITS  host byte to transmit
//  tx_valid     in   1          host write request
//  tx_ready     out  1          TX FIFO not full and loopback_en=0
//  rx_data      out  DATA_BITS  head of RX FIFO
//  rx_valid     out  1          RX FIFO not empty and loopback_en=0
//  rx_ready     in   1          host pop
//  rx_overrun   out  1          1-cycle pulse: byte completed while RX FIFO full
//  frame_err    out  1          1-cycle pulse: stop bit sampled 0
//  parity_err   out  1          1-cycle pulse: parity mismatch (0 when UART_PARITY_EN is undefined)
// BEHAVIOUR
//  - Reset values: uart_tx=1, tx_ready=0 during rst (1 after release), rx_valid=0,
//    all error pulses=0, FIFOs empty, both FSMs IDLE, synchroniser flops=1.
//  - uart_rx passes a 2-FF synchroniser. All RX timing is measured from the synchronised signal.
//  - RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//    IDLE: a falling edge loads the counter with DIV/2 and moves to START.
//    START: if the line is high at the sample, treat as a glitch and return to IDLE.
//    After that, sample every DIV cycles; data is LSB first.
//    STOP=1: write the byte to the RX FIFO on the next cycle.
//    STOP=0: pulse frame_err, discard the byte, wait for the line to go high, then go to IDLE.
//  - RX FIFO full at write: drop the new byte and pulse rx_overrun. FIFO contents are unchanged.
//  - TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each bit lasts exactly DIV cycles.
//    IDLE with TX FIFO non-empty: pop and start the next cycle.
//    STOP end with FIFO non-empty: go directly to START, so frames run back-to-back with no gap.
//  - Host writes: a write occurs when tx_valid & tx_ready. Host reads: a pop occurs when rx_valid & rx_ready.
//    rx_data is valid whenever rx_valid=1 (show-ahead FIFO).
//  - Loopback: each cycle where RX is not empty and TX is not full moves one entry RX->TX.
//    Latency from stop-bit sample to uart_tx start edge is <= 4 cycles when TX is idle.
//  - Changing loopback_en affects only FIFO transfers from the next cycle. Frames in flight complete.
//  - Simultaneous FIFO read and write on a full or empty FIFO is legal.
//    Count is unchanged when full; write-through is not allowed when empty.
//  - Reset asserted mid-frame: uart_tx goes to 1 asynchronously and the partial frame is lost.
// CONFIGURATION
//  UART_PARITY_EN defined: one even-parity bit follows the data in both directions.
//    RX mismatch pulses parity_err and discards the byte; the stop bit is still checked.
//  UART_PARITY_EN undefined: no parity bit; parity_err is tied to 0.
// STRUCTURE
//  - Package uart_pkg: rx_state_t and tx_state_t enums (IDLE, START, DATA, PARITY, STOP),
//    plus a function to compute DIV and the counter width (clog2).
//  - Sub-module uart_sync_fifo (WIDTH, DEPTH): show-ahead, registered full/empty flags.
//    It is instantiated twice.
//  - RX and TX FSMs live in the top module, each with its own divider counter.
// TESTING (CLK_HZ=1_000_000, BAUD=100_000 -> DIV=10; DATA_BITS=8; FIFO_DEPTH=16)
//  1. Reset: hold rst for 3 cycles -> uart_tx=1, rx_valid=0, no error pulses;
//     tx_ready=1 on the first cycle after release.
//  2. Loopback: loopback_en=1, drive frame 0xA5 on uart_rx ->
//     uart_tx emits 0,1,0,1,0,0,1,0,1,1 at 10 cycles per bit; rx_valid stays 0.
//  3. Host TX: loopback_en=0, write 0x3C then 0x00 on consecutive cycles ->
//     two 100-cycle frames, contiguous, LSB first.
//  4. Overrun: loopback_en=0, rx_ready=0, send 17 bytes 0x00..0x10 ->
//     16 entries 0x00..0x0F, one rx_overrun pulse; popping then yields 0x00..0x0F.
//  5. Errors: frame 0x55 with stop bit 0 -> one frame_err pulse and no FIFO write.
//     A 3-cycle low glitch -> no state change.
//  6. Parity (UART_PARITY_EN): 0x07 with odd parity bit -> parity_err pulse, byte discarded.
//     0x07 with correct parity -> accepted.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the buffered loopback UART.
//                FSM state encodings for the receiver and transmitter, plus
//                the baud divisor and divider-counter width computations.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    // Clock cycles per serial bit.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Width of a down-counter that must hold values 0..div-1.
    function automatic int uart_cnt_w(input int div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync_fifo
//  Description : Single-clock show-ahead FIFO with registered full/empty.
//                o_rd_data always shows the head entry while o_empty=0.
//                A write while full is accepted only if a read happens in
//                the same cycle; a read while empty is ignored (no
//                write-through).
//  Ports       : clk, rst (async, active-high)
//                i_wr_en/i_wr_data/o_full  - write side
//                i_rd_en/o_rd_data/o_empty - read side
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic             o_full,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic [c_AW:0]    w_count_nxt;
    logic             r_full;
    logic             r_empty;
    logic             w_rd_ok;
    logic             w_wr_ok;

    assign w_rd_ok = i_rd_en & ~r_empty;
    assign w_wr_ok = i_wr_en & (~r_full | w_rd_ok);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_nxt = r_count + (c_AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (c_AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_wr_ok) r_wptr <= r_wptr + c_AW'(1);
            if (w_rd_ok) r_rptr <= r_rptr + c_AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (c_AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    // Storage carries no reset; the flags alone say what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loopback_fifo
//  Description : Full-duplex UART with RX/TX FIFOs and run-time loopback.
//                loopback_en=1 drains received bytes straight into the TX
//                FIFO; loopback_en=0 exposes both FIFOs via valid/ready.
//  Ports       : clk, rst (async, active-high), uart_rx, uart_tx,
//                loopback_en, tx_data/tx_valid/tx_ready,
//                rx_data/rx_valid/rx_ready, rx_overrun, frame_err, parity_err
//  Config      : UART_PARITY_EN - adds one even-parity bit per frame.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_loopback_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    input  logic                 loopback_en,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_overrun,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int                c_DIV   = uart_div(CLK_HZ, BAUD);
    localparam int                c_CW    = uart_cnt_w(c_DIV);
    localparam int                c_BW    = $clog2(DATA_BITS);
    localparam logic [c_CW-1:0]   c_END   = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0]   c_HALF  = c_CW'(c_DIV / 2);
    localparam logic [c_CW-1:0]   c_ONE   = c_CW'(1);
    localparam logic [c_BW-1:0]   c_LAST  = c_BW'(DATA_BITS - 1);
    localparam logic [c_BW-1:0]   c_BONE  = c_BW'(1);

    // ---------------- control registers ----------------
    logic r_loop;       // loopback_en takes effect one cycle later
    logic r_alive;      // holds tx_ready low until reset has been released
    logic r_overrun;

    // ---------------- FIFO interface ----------------
    logic                 w_rxf_full, w_rxf_empty, w_rxf_rd;
    logic [DATA_BITS-1:0] w_rxf_rdata;
    logic                 w_txf_full, w_txf_empty, w_txf_rd, w_txf_wr;
    logic [DATA_BITS-1:0] w_txf_wdata, w_txf_rdata;

    // ---------------- RX path ----------------
    logic [1:0]           r_rx_sync;
    logic                 r_rx_prev;
    logic                 w_rx;
    logic                 w_rx_fall;
    logic                 w_rx_tick;
    rx_state_t            r_rx_state;
    logic [c_CW-1:0]      r_rx_cnt;
    logic [c_BW-1:0]      r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_brk;     // stop bit was low: wait for idle line
    logic                 r_rx_wr;
    logic                 r_frame_err;

    // ---------------- TX path ----------------
    tx_state_t            r_tx_state;
    logic [c_CW-1:0]      r_tx_cnt;
    logic [c_BW-1:0]      r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx;
    logic                 w_tx_tick;

`ifdef UART_PARITY_EN
    logic r_rx_par_bad;
    logic r_parity_err;
    logic r_tx_par;
    logic w_par_bad;
    assign w_par_bad  = w_rx ^ (^r_rx_shift);
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // ---------------- FIFO transfers ----------------
    assign w_rxf_rd    = r_loop ? ~w_txf_full : rx_ready;
    assign w_txf_wr    = r_loop ? (~w_rxf_empty & ~w_txf_full) : (tx_valid & tx_ready);
    assign w_txf_wdata = r_loop ? w_rxf_rdata : tx_data;

    assign tx_ready   = r_alive & ~r_loop & ~w_txf_full;
    assign rx_valid   = ~r_loop & ~w_rxf_empty;
    assign rx_data    = w_rxf_rdata;
    assign rx_overrun = r_overrun;
    assign frame_err  = r_frame_err;
    assign uart_tx    = r_tx;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (r_rx_wr),
        .i_wr_data (r_rx_shift),
        .o_full    (w_rxf_full),
        .i_rd_en   (w_rxf_rd),
        .o_rd_data (w_rxf_rdata),
        .o_empty   (w_rxf_empty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_txf_wr),
        .i_wr_data (w_txf_wdata),
        .o_full    (w_txf_full),
        .i_rd_en   (w_txf_rd),
        .o_rd_data (w_txf_rdata),
        .o_empty   (w_txf_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_loop    <= 1'b0;
            r_alive   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_loop    <= loopback_en;
            r_alive   <= 1'b1;
            // A pop in the same cycle frees a slot, so that is not an overrun.
            r_overrun <= r_rx_wr & w_rxf_full & ~w_rxf_rd;
        end
    end

    // ---------------- RX synchroniser and FSM ----------------
    assign w_rx      = r_rx_sync[1];
    assign w_rx_fall = r_rx_prev & ~w_rx;
    assign w_rx_tick = (r_rx_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_sync <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_sync <= {r_rx_sync[0], uart_rx};
            r_rx_prev <= w_rx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_brk     <= 1'b0;
            r_rx_wr      <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            r_rx_par_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_wr     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_rx_state != RX_IDLE && !w_rx_tick) r_rx_cnt <= r_rx_cnt - c_ONE;
            case (r_rx_state)
                RX_IDLE: begin
                    if (w_rx_fall) begin
                        r_rx_cnt   <= c_HALF;       // first sample lands mid start bit
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (w_rx_tick) begin
                        if (w_rx) begin
                            r_rx_state <= RX_IDLE;  // glitch, not a start bit
                        end else begin
                            r_rx_cnt   <= c_END;
                            r_rx_bit   <= '0;
                            r_rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_rx_tick) begin
                        r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_cnt   <= c_END;
                        if (r_rx_bit == c_LAST) begin
`ifdef UART_PARITY_EN
                            r_rx_state <= RX_PARITY;
`else
                            r_rx_state <= RX_STOP;
`endif
                        end else begin
                            r_rx_bit <= r_rx_bit + c_BONE;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (w_rx_tick) begin
                        r_rx_par_bad <= w_par_bad;
                        r_parity_err <= w_par_bad;
                        r_rx_cnt     <= c_END;
                        r_rx_state   <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (r_rx_brk) begin
                        if (w_rx) begin
                            r_rx_brk   <= 1'b0;
                            r_rx_state <= RX_IDLE;
                        end
                    end else if (w_rx_tick) begin
                        if (w_rx) begin
`ifdef UART_PARITY_EN
                            r_rx_wr <= ~r_rx_par_bad;
`else
                            r_rx_wr <= 1'b1;
`endif
                            r_rx_state <= RX_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_rx_brk    <= 1'b1;
                        end
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- TX FSM ----------------
    assign w_tx_tick = (r_tx_cnt == '0);

    // Pop from IDLE, or at the end of a stop bit so frames run back-to-back.
    always_comb begin
        w_txf_rd = 1'b0;
        if (!w_txf_empty) begin
            if (r_tx_state == TX_IDLE) w_txf_rd = 1'b1;
            if (r_tx_state == TX_STOP && w_tx_tick) w_txf_rd = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx       <= 1'b1;
`ifdef UART_PARITY_EN
            r_tx_par   <= 1'b0;
`endif
        end else begin
            if (r_tx_state != TX_IDLE && !w_tx_tick) r_tx_cnt <= r_tx_cnt - c_ONE;
            if (w_txf_rd) begin
                r_tx_shift <= w_txf_rdata;
`ifdef UART_PARITY_EN
                r_tx_par   <= ^w_txf_rdata;
`endif
                r_tx_cnt   <= c_END;
                r_tx       <= 1'b0;
                r_tx_state <= TX_START;
            end else begin
                case (r_tx_state)
                    TX_START: begin
                        if (w_tx_tick) begin
                            r_tx       <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= '0;
                            r_tx_cnt   <= c_END;
                            r_tx_state <= TX_DATA;
                        end
                    end
                    TX_DATA: begin
                        if (w_tx_tick) begin
                            r_tx_cnt <= c_END;
                            if (r_tx_bit == c_LAST) begin
`ifdef UART_PARITY_EN
                                r_tx       <= r_tx_par;
                                r_tx_state <= TX_PARITY;
`else
                                r_tx       <= 1'b1;
                                r_tx_state <= TX_STOP;
`endif
                            end else begin
                                r_tx       <= r_tx_shift[0];
                                r_tx_shift <= r_tx_shift >> 1;
                                r_tx_bit   <= r_tx_bit + c_BONE;
                            end
                        end
                    end
`ifdef UART_PARITY_EN
                    TX_PARITY: begin
                        if (w_tx_tick) begin
                            r_tx       <= 1'b1;
                            r_tx_cnt   <= c_END;
                            r_tx_state <= TX_STOP;
                        end
                    end
`endif
                    TX_STOP: begin
                        if (w_tx_tick) r_tx_state <= TX_IDLE;
                    end
                    default: r_tx_state <= TX_IDLE;
                endcase
            end
        end
    end

endmodule : uart_loopback_fifo
`default_nettype wire

// File: tb/tb_uart_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_loopback_fifo
//  Description : Directed self-checking bench for uart_loopback_fifo with
//                DIV=10, 8 data bits, 16-entry FIFOs. Honours
//                UART_PARITY_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_loopback_fifo;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       uart_tx;
    logic       loopback_en = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       frame_err;
    logic       parity_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ovr    = 0;
    int n_ferr   = 0;
    int n_perr   = 0;
    int n_rxv_lb = 0;

    uart_loopback_fifo #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .DATA_BITS  (8),
        .FIFO_DEPTH (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .loopback_en (loopback_en),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .frame_err   (frame_err),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_overrun) n_ovr++;
            if (frame_err) n_ferr++;
            if (parity_err) n_perr++;
            if (loopback_en && rx_valid) n_rxv_lb++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame bits in line order: bit 0 is the start bit.
    function automatic logic [NB-1:0] build_frame(input logic [7:0] d, input logic stop);
`ifdef UART_PARITY_EN
        return {stop, ^d, d, 1'b0};
`else
        return {stop, d, 1'b0};
`endif
    endfunction

    task automatic send_bits(input logic [NB-1:0] b);
        for (int i = 0; i < NB; i++) begin
            uart_rx = b[i];
            tick(10);
        end
        uart_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(build_frame(d, stop));
    endtask

    // Wait (bounded) for a start edge on uart_tx, then sample each bit mid-way.
    task automatic capture_frame(input int max_wait, output logic [NB-1:0] bits, output int waited);
        waited = 0;
        bits   = '1;
        do begin
            @(negedge clk);
            waited++;
        end while (uart_tx !== 1'b0 && waited < max_wait);
        if (uart_tx === 1'b0) begin
            repeat (4) @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                bits[i] = uart_tx;
                if (i < NB - 1) repeat (10) @(negedge clk);
            end
        end
    endtask

    task automatic pop();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] f1;
        logic [NB-1:0] f2;
        int            w1;
        int            gap;

        // ---- 1. reset ----
        tick(3);
        check_eq("rst_uart_tx",   32'(uart_tx),   32'd1);
        check_eq("rst_tx_ready",  32'(tx_ready),  32'd0);
        check_eq("rst_rx_valid",  32'(rx_valid),  32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        tick(1);
        check_eq("rel_tx_ready",  32'(tx_ready),  32'd1);

        // ---- 2. loopback of 0xA5 ----
        loopback_en = 1'b1;
        tick(2);
        fork
            send_frame(8'hA5, 1'b1);
            capture_frame(400, f1, w1);
        join
        tick(10);
        check_eq("lb_frame",    32'(f1),       32'(build_frame(8'hA5, 1'b1)));
        check_eq("lb_rx_valid", 32'(n_rxv_lb), 32'd0);

        // ---- 3. host TX: 0x3C then 0x00 back-to-back ----
        loopback_en = 1'b0;
        tick(2);
        check_eq("host_tx_ready", 32'(tx_ready), 32'd1);
        fork
            begin
                tx_valid = 1'b1;
                tx_data  = 8'h3C;
                tick(1);
                tx_data  = 8'h00;
                tick(1);
                tx_valid = 1'b0;
            end
            begin
                capture_frame(50, f1, w1);
                capture_frame(200, f2, gap);
            end
        join
        check_eq("host_frame0", 32'(f1),  32'(build_frame(8'h3C, 1'b1)));
        check_eq("host_frame1", 32'(f2),  32'(build_frame(8'h00, 1'b1)));
        check_eq("host_gap",    32'(gap), 32'd6);

        // ---- 4. overrun: 17 bytes into a 16-deep RX FIFO ----
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        tick(20);
        check_eq("ovr_pulses",   32'(n_ovr),    32'd1);
        check_eq("ovr_rx_valid", 32'(rx_valid), 32'd1);
        for (int i = 0; i < 16; i++) begin
            check_eq("ovr_pop_data", 32'(rx_data), 32'(i));
            pop();
        end
        check_eq("ovr_drained", 32'(rx_valid), 32'd0);

        // ---- 5. framing error and start glitch ----
        send_frame(8'h55, 1'b0);
        tick(20);
        check_eq("ferr_pulses",   32'(n_ferr),   32'd1);
        check_eq("ferr_rx_valid", 32'(rx_valid), 32'd0);
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(30);
        check_eq("glitch_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("glitch_ferr",     32'(n_ferr),   32'd1);
        send_frame(8'h5A, 1'b1);
        tick(5);
        check_eq("post_glitch_valid", 32'(rx_valid), 32'd1);
        check_eq("post_glitch_data",  32'(rx_data),  32'h5A);
        pop();
        check_eq("ovr_total", 32'(n_ovr), 32'd1);

        // ---- 6. parity ----
`ifdef UART_PARITY_EN
        send_bits(11'b1_0_00000111_0);   // 0x07 with wrong (odd) parity bit
        tick(5);
        check_eq("par_bad_pulses", 32'(n_perr),   32'd1);
        check_eq("par_bad_valid",  32'(rx_valid), 32'd0);
        send_bits(11'b1_1_00000111_0);   // 0x07 with correct parity bit
        tick(5);
        check_eq("par_ok_valid",   32'(rx_valid), 32'd1);
        check_eq("par_ok_data",    32'(rx_data),  32'h07);
        pop();
        check_eq("par_ok_pulses",  32'(n_perr),   32'd1);
`else
        check_eq("no_parity_err", 32'(n_perr), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_loopback_fifo
`default_nettype wire
